// File: rtl/decode_queue.sv
// Instruction buffer plus registered decoder: a DEPTH-entry FIFO feeds an output register
// holding the decoded control bundle, handed to execute over valid/ready.
module decode_queue #(
  parameter int unsigned DEPTH    = 4,
  parameter int unsigned XLEN     = 32,
  parameter int unsigned ENABLE_M = 0
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            flush,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [31:0]     in_instr,
  input  logic [XLEN-1:0] in_pc,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [31:0]     out_instr,
  output logic [XLEN-1:0] out_pc,
  output logic            RegWrite,
  output logic            ALUsrc,
  output logic            Branch,
  output logic            Jump,
  output logic            destsrc,
  output logic            MemWrite,
  output logic [4:0]      ALUctrl,
  output logic [2:0]      ImmSrc,
  output logic [2:0]      memCtrl,
  output logic            UI_control,
  output logic            RD1_control,
  output logic            PC_RD1_control,
  output logic            four_imm_control,
  output logic            illegal
);

  localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CW = $clog2(DEPTH + 1);
  localparam logic [CW-1:0] Full = CW'(DEPTH);

  typedef struct packed {
    logic       reg_write;
    logic       alu_src;
    logic       branch;
    logic       jump;
    logic       dest_src;
    logic       mem_write;
    logic [4:0] alu_ctrl;
    logic [2:0] imm_src;
    logic [2:0] mem_ctrl;
    logic       ui_sel;
    logic       rd1_sel;
    logic       pc_rd1_sel;
    logic       four_imm_sel;
    logic       illegal;
  } ctrl_t;

  logic [31:0]     mem_instr [DEPTH];
  logic [XLEN-1:0] mem_pc    [DEPTH];
  logic [AW-1:0]   wr_ptr_q, rd_ptr_q;
  logic [CW-1:0]   count_q;
  logic            out_valid_q;
  logic [31:0]     out_instr_q;
  logic [XLEN-1:0] out_pc_q;
  ctrl_t           ctrl_q, ctrl_d;

  logic            push, load, have_head, pop, bypass, wr;
  logic [31:0]     src_instr;
  logic [XLEN-1:0] src_pc;

  assign in_ready  = !rst && (count_q < Full);
  assign push      = in_valid && in_ready;
  assign load      = !out_valid_q || out_ready;
  assign have_head = (count_q != '0);
  assign pop       = load && have_head;
  // An empty FIFO lets the incoming instruction skip straight into the output register.
  assign bypass    = load && !have_head && push;
  assign wr        = push && !bypass;
  assign src_instr = have_head ? mem_instr[rd_ptr_q] : in_instr;
  assign src_pc    = have_head ? mem_pc[rd_ptr_q] : in_pc;

  always_comb begin
    logic [2:0] f3;
    logic [6:0] f7;
    f3                  = src_instr[14:12];
    f7                  = src_instr[31:25];
    ctrl_d              = '0;
    ctrl_d.mem_ctrl     = f3;
    ctrl_d.ui_sel       = 1'b1;
    ctrl_d.rd1_sel      = 1'b1;
    ctrl_d.pc_rd1_sel   = 1'b1;
    ctrl_d.four_imm_sel = 1'b1;
    unique case (src_instr[6:0])
      7'b0110011: begin
        if (f7 == 7'b0000001) begin
          if (ENABLE_M != 0) begin
            ctrl_d.reg_write = 1'b1;
            ctrl_d.alu_ctrl  = {2'b10, f3};
          end else begin
            ctrl_d.illegal = 1'b1;
          end
        end else begin
          ctrl_d.reg_write = 1'b1;
          ctrl_d.alu_ctrl  = {1'b0, src_instr[30], f3};
        end
      end
      7'b0010011: begin
        ctrl_d.reg_write = 1'b1;
        ctrl_d.alu_src   = 1'b1;
        ctrl_d.alu_ctrl  = {1'b0, (f3 == 3'b101) && src_instr[30], f3};
      end
      7'b0000011: begin
        ctrl_d.reg_write = 1'b1;
        ctrl_d.alu_src   = 1'b1;
        ctrl_d.dest_src  = 1'b1;
      end
      7'b1100011: begin
        ctrl_d.branch   = 1'b1;
        ctrl_d.imm_src  = 3'd1;
        ctrl_d.alu_ctrl = {2'b00, f3};
      end
      7'b0100011: begin
        ctrl_d.mem_write = 1'b1;
        ctrl_d.alu_src   = 1'b1;
        ctrl_d.imm_src   = 3'd2;
      end
      7'b0110111, 7'b0010111: begin
        ctrl_d.reg_write = 1'b1;
        ctrl_d.alu_src   = 1'b1;
        ctrl_d.imm_src   = 3'd3;
        ctrl_d.rd1_sel   = 1'b0;
        ctrl_d.ui_sel    = (src_instr[6:0] != 7'b0110111);
      end
      7'b1101111: begin
        ctrl_d.reg_write    = 1'b1;
        ctrl_d.alu_src      = 1'b1;
        ctrl_d.imm_src      = 3'd4;
        ctrl_d.jump         = 1'b1;
        ctrl_d.rd1_sel      = 1'b0;
        ctrl_d.four_imm_sel = 1'b0;
      end
      7'b1100111: begin
        ctrl_d.reg_write    = 1'b1;
        ctrl_d.alu_src      = 1'b1;
        ctrl_d.jump         = 1'b1;
        ctrl_d.rd1_sel      = 1'b0;
        ctrl_d.pc_rd1_sel   = 1'b0;
        ctrl_d.four_imm_sel = 1'b0;
      end
      default: ctrl_d.illegal = 1'b1;
    endcase
  end

  always_ff @(posedge clk) begin
    if (wr && !rst && !flush) begin
      mem_instr[wr_ptr_q] <= in_instr;
      mem_pc[wr_ptr_q]    <= in_pc;
    end
  end

  always_ff @(posedge clk) begin
    if (rst || flush) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      out_valid_q <= 1'b0;
      out_instr_q <= '0;
      out_pc_q    <= '0;
      ctrl_q      <= '0;
    end else begin
      if (wr) wr_ptr_q <= wr_ptr_q + AW'(1);
      if (pop) rd_ptr_q <= rd_ptr_q + AW'(1);
      if (wr && !pop) count_q <= count_q + CW'(1);
      else if (!wr && pop) count_q <= count_q - CW'(1);
      if (load) begin
        out_valid_q <= pop || bypass;
        if (pop || bypass) begin
          out_instr_q <= src_instr;
          out_pc_q    <= src_pc;
          ctrl_q      <= ctrl_d;
        end
      end
    end
  end

  assign out_valid        = out_valid_q;
  assign out_instr        = out_instr_q;
  assign out_pc           = out_pc_q;
  assign RegWrite         = ctrl_q.reg_write;
  assign ALUsrc           = ctrl_q.alu_src;
  assign Branch           = ctrl_q.branch;
  assign Jump             = ctrl_q.jump;
  assign destsrc          = ctrl_q.dest_src;
  assign MemWrite         = ctrl_q.mem_write;
  assign ALUctrl          = ctrl_q.alu_ctrl;
  assign ImmSrc           = ctrl_q.imm_src;
  assign memCtrl          = ctrl_q.mem_ctrl;
  assign UI_control       = ctrl_q.ui_sel;
  assign RD1_control      = ctrl_q.rd1_sel;
  assign PC_RD1_control   = ctrl_q.pc_rd1_sel;
  assign four_imm_control = ctrl_q.four_imm_sel;
  assign illegal          = ctrl_q.illegal;

endmodule

// File: tb/tb_decode_queue.sv
// Randomised bench for decode_queue: a queue-based reference model and a PC scoreboard,
// run against an RV32M-enabled instance and a base-only instance driven in lockstep.
module tb_decode_queue;
  localparam int DEPTH = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b1, flush = 1'b0, in_valid = 1'b0, out_ready = 1'b0;
  logic [31:0] in_instr = '0, in_pc = '0;

  logic        in_ready, out_valid, in_ready_n, out_valid_n;
  logic [31:0] out_instr, out_pc, out_instr_n, out_pc_n;
  logic        rw, asrc, br, jmp, dsrc, mw, ui, rd1, pcrd1, four, ill;
  logic        rw_n, asrc_n, br_n, jmp_n, dsrc_n, mw_n, ui_n, rd1_n, pcrd1_n, four_n, ill_n;
  logic [4:0]  aluc, aluc_n;
  logic [2:0]  imms, memc, imms_n, memc_n;

  always #5 clk = ~clk;

  decode_queue #(.DEPTH(DEPTH), .XLEN(32), .ENABLE_M(1)) dut (
    .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
    .in_instr(in_instr), .in_pc(in_pc), .out_valid(out_valid), .out_ready(out_ready),
    .out_instr(out_instr), .out_pc(out_pc), .RegWrite(rw), .ALUsrc(asrc), .Branch(br),
    .Jump(jmp), .destsrc(dsrc), .MemWrite(mw), .ALUctrl(aluc), .ImmSrc(imms),
    .memCtrl(memc), .UI_control(ui), .RD1_control(rd1), .PC_RD1_control(pcrd1),
    .four_imm_control(four), .illegal(ill)
  );

  decode_queue #(.DEPTH(DEPTH), .XLEN(32), .ENABLE_M(0)) dut_n (
    .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(in_ready_n),
    .in_instr(in_instr), .in_pc(in_pc), .out_valid(out_valid_n), .out_ready(out_ready),
    .out_instr(out_instr_n), .out_pc(out_pc_n), .RegWrite(rw_n), .ALUsrc(asrc_n),
    .Branch(br_n), .Jump(jmp_n), .destsrc(dsrc_n), .MemWrite(mw_n), .ALUctrl(aluc_n),
    .ImmSrc(imms_n), .memCtrl(memc_n), .UI_control(ui_n), .RD1_control(rd1_n),
    .PC_RD1_control(pcrd1_n), .four_imm_control(four_n), .illegal(ill_n)
  );

  wire [21:0] got_m = {rw, asrc, br, jmp, dsrc, mw, aluc, imms, memc, ui, rd1, pcrd1, four, ill};
  wire [21:0] got_n = {rw_n, asrc_n, br_n, jmp_n, dsrc_n, mw_n, aluc_n, imms_n, memc_n,
                       ui_n, rd1_n, pcrd1_n, four_n, ill_n};

  int errors = 0;
  int checks = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Expected control bundle, same field order as got_m/got_n.
  function automatic logic [21:0] exp_bundle(input logic [31:0] ins, input bit em);
    logic rwx, as, b, j, ds, mwx, ilx, uix, r1, pr1, f4;
    logic [4:0] ac;
    logic [2:0] is;
    logic [2:0] f3;
    f3 = ins[14:12];
    {rwx, as, b, j, ds, mwx, ilx} = '0;
    ac = '0;
    is = '0;
    uix = (ins[6:0] != 7'h37);
    r1 = !(ins[6:0] inside {7'h37, 7'h17, 7'h6f, 7'h67});
    pr1 = (ins[6:0] != 7'h67);
    f4 = !(ins[6:0] inside {7'h6f, 7'h67});
    case (ins[6:0])
      7'h33: if (ins[31:25] == 7'h01 && !em) ilx = 1;
             else begin
               rwx = 1;
               ac = (ins[31:25] == 7'h01) ? {2'b10, f3} : {1'b0, ins[30], f3};
             end
      7'h13: begin rwx = 1; as = 1; ac = {1'b0, f3 == 3'd5 ? ins[30] : 1'b0, f3}; end
      7'h03: begin rwx = 1; as = 1; ds = 1; end
      7'h63: begin b = 1; is = 1; ac = {2'b00, f3}; end
      7'h23: begin mwx = 1; as = 1; is = 2; end
      7'h37, 7'h17: begin rwx = 1; as = 1; is = 3; end
      7'h6f: begin rwx = 1; as = 1; is = 4; j = 1; end
      7'h67: begin rwx = 1; as = 1; j = 1; end
      default: ilx = 1;
    endcase
    return {rwx, as, b, j, ds, mwx, ac, is, f3, uix, r1, pr1, f4, ilx};
  endfunction

  logic [63:0] mq[$];
  logic [31:0] exp_q[$];
  logic        mov = 0;
  logic [31:0] moi = 0, mop = 0;

  // One clock: drive inputs, advance the reference model, then compare after the edge.
  task automatic cycle(input logic r, input logic f, input logic iv, input logic [31:0] ins,
                       input logic [31:0] pc, input logic ordy);
    logic m_rdy, push, used;
    logic [63:0] e;
    rst = r; flush = f; in_valid = iv; in_instr = ins; in_pc = pc; out_ready = ordy;
    #1;
    m_rdy = !r && (mq.size() < DEPTH);
    check("in_ready", in_ready, m_rdy);
    if (!r && !f && out_valid && ordy) begin
      if (exp_q.size() == 0) check("sb_extra", 1, 0);
      else check("sb_pc", out_pc, exp_q.pop_front());
    end
    if (r || f) begin
      mq.delete(); exp_q.delete(); mov = 0; moi = 0; mop = 0;
    end else begin
      push = iv && m_rdy;
      used = 0;
      if (!mov || ordy) begin
        if (mq.size() > 0) begin
          e = mq.pop_front(); moi = e[63:32]; mop = e[31:0]; mov = 1;
        end else if (push) begin
          moi = ins; mop = pc; mov = 1; used = 1;
        end else mov = 0;
      end
      if (push && !used) mq.push_back({ins, pc});
      if (push) exp_q.push_back(pc);
    end
    @(posedge clk);
    #1;
    check("out_valid", out_valid, mov);
    check("out_valid_n", out_valid_n, mov);
    if (mov) begin
      check("out_pc", out_pc, mop);
      check("out_instr", out_instr, moi);
      check("bundle_m", got_m, exp_bundle(moi, 1));
      check("bundle_n", got_n, exp_bundle(moi, 0));
    end
  endtask

  function automatic logic [31:0] rand_instr();
    logic [6:0] ops [11] = '{7'h33, 7'h13, 7'h03, 7'h63, 7'h23, 7'h37, 7'h17, 7'h6f, 7'h67,
                             7'h33, 7'h7f};
    logic [6:0] f7s [4] = '{7'h00, 7'h20, 7'h01, 7'h55};
    logic [31:0] r;
    r = $urandom;
    r[6:0] = ops[$urandom_range(0, 10)];
    if (r[6:0] == 7'h33) r[31:25] = f7s[$urandom_range(0, 3)];
    return r;
  endfunction

  initial begin
    logic [31:0] pc;
    logic ok;
    cycle(1, 0, 0, 0, 0, 0);
    cycle(1, 0, 1, 32'h00500093, 0, 1);
    check("rst_bundle_m", got_m, 0);
    check("rst_bundle_n", got_n, 0);
    check("rst_out_instr", out_instr, 0);
    check("rst_out_pc", out_pc, 0);

    cycle(0, 0, 1, 32'h00500093, 0, 1);
    check("addi_rw", rw, 1);
    check("addi_alusrc", asrc, 1);
    check("addi_aluctrl", aluc, 5'b00000);
    check("addi_immsrc", imms, 0);
    check("addi_illegal", ill, 0);
    cycle(0, 0, 0, 0, 0, 1);

    for (int i = 0; i < 5; i++) cycle(0, 0, 1, 32'h00500093, 32'(i * 4), 0);
    #0 check("full_in_ready", in_ready, 0);
    for (int i = 0; i < 5; i++) begin
      check("order_pc", out_pc, 32'(i * 4));
      cycle(0, 0, 0, 0, 0, 1);
    end

    cycle(0, 0, 1, 32'h02208033, 32'h40, 1);
    check("mul_aluctrl", aluc, 5'b10000);
    check("mul_n_illegal", ill_n, 1);
    check("mul_n_regwrite", rw_n, 0);
    cycle(0, 0, 1, 32'h4020D093, 32'h44, 1);
    check("srai_aluctrl", aluc, 5'b01101);
    cycle(0, 0, 1, 32'h40208033, 32'h48, 1);
    check("sub_aluctrl", aluc, 5'b01000);
    cycle(0, 0, 1, 32'h000000E7, 32'h4c, 1);
    check("jalr_jump", jmp, 1);
    check("jalr_pcrd1", pcrd1, 0);
    check("jalr_four", four, 0);
    check("jalr_rd1", rd1, 0);
    cycle(0, 0, 0, 0, 0, 1);

    for (int i = 0; i < 4; i++) cycle(0, 0, 1, 32'h00500093, 32'h100 + 32'(i * 4), 0);
    cycle(0, 1, 1, 32'h00500093, 32'h200, 0);
    check("flush_bundle", got_m, 0);
    for (int i = 0; i < 4; i++) cycle(0, 0, 0, 0, 0, 1);

    pc = 32'h1000;
    for (int i = 0; i < 1000; i++) begin
      ok = (mq.size() < DEPTH);
      if (i == 600) cycle(1, 0, 0, 0, 0, 0);
      else begin
        logic iv;
        iv = ($urandom_range(0, 3) != 0);
        cycle(0, 0, iv, rand_instr(), pc, ($urandom_range(0, 2) != 0));
        if (iv && ok) pc = pc + 4;
      end
    end
    for (int i = 0; i < DEPTH + 3; i++) cycle(0, 0, 0, 0, 0, 1);
    check("sb_drained", 32'(exp_q.size()), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
